counter_sram_mp: RTL
====================

// Module: counter_sram_mp
// PURPOSE
//  Parametrised multi-port SRAM for the counter subsystem; successor to the dual-channel counter buffer.
//  NUM_PORTS independent read ports; one shared write path with fixed-priority arbitration.
//  Selectable read-during-write mode; per-port dropped-write flags.
//  Sequential clear engine zeroes the array without blocking reads.
//  Sits between the counter cores (high-priority ports) and the system-bus bridge (highest index port).
// PARAMETERS
//  NUM_PORTS   2     number of ports, legal range 1..8
//  ADDR_WIDTH  12    address width per port
//  DATA_WIDTH  18    data word width
//  DEPTH       4096  words; must satisfy DEPTH <= 2**ADDR_WIDTH
//  WRITE_FIRST 0     0: read returns old data on same-address write; 1: returns new data
// PORTS
//  i_clk      in   1                       clock; all logic on rising edge
//  i_rst      in   1                       reset, asynchronous, active-high
//  i_addr     in   NUM_PORTS*ADDR_WIDTH    per-port address, packed [NUM_PORTS-1:0][ADDR_WIDTH-1:0]
//  i_we       in   NUM_PORTS               per-port write request
//  i_wdata    in   NUM_PORTS*DATA_WIDTH    per-port write data
//  o_rdata    out  NUM_PORTS*DATA_WIDTH    per-port registered read data
//  o_drop     out  NUM_PORTS               1-cycle pulse: that port's write was not performed
//  i_clear    in   1                       start clear of the whole array (level sampled in IDLE)
//  o_busy     out  1                       clear engine active
// BEHAVIOUR
//  Reset (i_rst=1, async): o_rdata=0, o_drop=0, o_busy=0, FSM=IDLE, clear pointer=0.
//  Memory contents are not touched by reset.
//  Write grant: lowest port index with i_we=1 and addr<DEPTH wins. At most 1 array write per cycle.
//  o_drop[p]=1 on the next cycle if port p had i_we=1 and was not granted. Covers all of:
//   - a lower port won
//   - addr >= DEPTH
//   - FSM=CLEAR
//  Read: every port reads every cycle; o_rdata[p] = mem[i_addr[p]] at 1-cycle latency.
//  If i_addr[p] >= DEPTH, o_rdata[p] = 0.
//  Read-during-write when read addr == granted write addr in the same cycle:
//   - WRITE_FIRST=1: returns the granted wdata
//   - WRITE_FIRST=0: returns the prior contents
//   - Applies to every port, the writer included.
//  FSM IDLE: if i_clear=1 -> CLEAR, pointer=0; o_busy=1 from the next cycle.
//  FSM CLEAR: writes 0 to mem[pointer] each cycle, pointer++.
//   - After the write to DEPTH-1 -> IDLE; o_busy=0 on the following cycle.
//   - Total busy time: exactly DEPTH cycles.
//   - All user writes are dropped (o_drop pulses).
//   - Reads continue; they may see partially cleared data.
//   - Clear write counts as the granted write for read-during-write rules.
//   - i_clear is ignored while in CLEAR (no restart).
//  Reset mid-clear: FSM -> IDLE at once, o_busy=0; the array stays partially cleared.
//  Simultaneous i_clear and i_we in IDLE: that cycle's granted write is performed, then CLEAR starts.
//  Elaboration error if DEPTH > 2**ADDR_WIDTH or NUM_PORTS is outside 1..8.
// CONFIGURATION
//  COUNTER_SRAM_STATS_EN defined:
//   - adds output o_drop_cnt [15:0]
//   - counts dropped writes summed over all ports per cycle (+popcount of the drop vector)
//   - saturates at 16'hFFFF; reset value 0
//   - cleared to 0 when a clear sequence starts
//  COUNTER_SRAM_STATS_EN undefined: port o_drop_cnt and its logic are absent;
//   all other behaviour is identical.
// TESTING
//  1. Single write then read. NUM_PORTS=2: p0 writes 0x2ABCD @0x010, p1 reads 0x010 next cycle
//     -> o_rdata[1]=0x2ABCD one cycle later; o_drop=0.
//  2. Write conflict. p0 and p1 write 0x1 / 0x2 to 0x020 in the same cycle
//     -> mem[0x020]=0x1; o_drop=2'b10 for exactly one cycle.
//  3. Read-during-write. mem[0x030]=0x5; p0 writes 0x7 @0x030 while p1 reads 0x030
//     -> o_rdata[1]=0x5 with WRITE_FIRST=0, 0x7 with WRITE_FIRST=1.
//  4. Full clear. Fill DEPTH=16; pulse i_clear; p1 writes during busy
//     -> o_busy high for exactly 16 cycles; all reads 0 afterwards; o_drop[1] pulses
//        (with STATS_EN: o_drop_cnt counts them).
//  5. Reset mid-clear. DEPTH=16; assert i_rst 5 cycles into CLEAR
//     -> o_busy=0 asynchronously; addr 0..4 read 0; addr 5..15 keep old data.
//  6. Out-of-range address. DEPTH=3000, ADDR_WIDTH=12: write @0xFFF, read 0xFFF
//     -> o_drop pulses; o_rdata=0; no in-range word is changed.

Source files
------------

// File: rtl/counter_sram_mp_if.sv
`default_nettype none
//==============================================================================
// Module      : counter_sram_mp_if
// Description : Per-port bus bundle for the counter_sram_mp multi-port SRAM.
//               Carries the address, write-request and write-data vectors
//               towards the memory. It carries the registered read data and
//               the dropped-write pulses back to the requesters.
// Signals     : i_addr  [NUM_PORTS][ADDR_WIDTH]  per-port address
//               i_we    [NUM_PORTS]              per-port write request
//               i_wdata [NUM_PORTS][DATA_WIDTH]  per-port write data
//               o_rdata [NUM_PORTS][DATA_WIDTH]  per-port read data (1-cycle)
//               o_drop  [NUM_PORTS]              write-not-performed pulse
// Modports    : master (requester side), slave (memory side)
// Revision    : 1.0  initial release
//==============================================================================
interface counter_sram_mp_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 18
);
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] i_addr;
    logic [NUM_PORTS-1:0]                 i_we;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] i_wdata;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] o_rdata;
    logic [NUM_PORTS-1:0]                 o_drop;

    modport master (
        output i_addr, i_we, i_wdata,
        input  o_rdata, o_drop
    );

    modport slave (
        input  i_addr, i_we, i_wdata,
        output o_rdata, o_drop
    );
endinterface
`default_nettype wire

// File: rtl/counter_sram_mp.sv
`default_nettype none
//==============================================================================
// Module      : counter_sram_mp
// Description : Multi-port SRAM for the counter subsystem. NUM_PORTS read
//               ports read every cycle with 1-cycle latency. A single shared
//               write path is granted to the lowest-indexed requesting port
//               whose address is in range. A sequential clear engine zeroes
//               the array one word per cycle while reads continue.
// Ports       : i_clk      clock, rising edge
//               i_rst      asynchronous active-high reset
//               bus        counter_sram_mp_if.slave (addr/we/wdata/rdata/drop)
//               i_clear    start a clear of the whole array (sampled in IDLE)
//               o_busy     clear engine active
//               o_drop_cnt saturating dropped-write counter
//                          (only with COUNTER_SRAM_STATS_EN defined)
// Macro       : COUNTER_SRAM_STATS_EN adds o_drop_cnt and its counter.
// Revision    : 1.0  initial release
//==============================================================================
module counter_sram_mp #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 18,
    parameter int DEPTH       = 4096,
    parameter int WRITE_FIRST = 0
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    counter_sram_mp_if.slave bus,
    input  wire logic        i_clear,
`ifdef COUNTER_SRAM_STATS_EN
    output logic [15:0]      o_drop_cnt,
`endif
    output logic             o_busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_DEPTH_EXT = DEPTH[ADDR_WIDTH:0];
    localparam logic [IDX_W-1:0]    c_LAST_IDX  = IDX_W'(DEPTH - 1);

    if (NUM_PORTS < 1 || NUM_PORTS > 8 || DEPTH < 1 ||
        longint'(DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_params
        $error("counter_sram_mp: illegal NUM_PORTS/DEPTH/ADDR_WIDTH combination");
    end

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                               r_state_q, w_state_d;
    logic [IDX_W-1:0]                     r_ptr_q,   w_ptr_d;
    logic                                 r_busy_q;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] r_rdata_q, w_rdata_d;
    logic [NUM_PORTS-1:0]                 r_drop_q,  w_drop_d;

    logic [NUM_PORTS-1:0]                 w_in_range;
    logic [IDX_W-1:0]                     w_rd_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0]                 w_grant;
    logic                                 w_found;
    logic                                 w_wr_en;
    logic [IDX_W-1:0]                     w_wr_idx;
    logic [DATA_WIDTH-1:0]                w_wr_data;

    // In-range addresses always fit in IDX_W bits, so truncation is exact
    // whenever the index is actually used.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign w_in_range[p] = ({1'b0, bus.i_addr[p]} < c_DEPTH_EXT);
        assign w_rd_idx[p]   = bus.i_addr[p][IDX_W-1:0];
    end

    // Single write path: clear engine owns it while clearing, otherwise the
    // lowest-indexed eligible port wins.
    always_comb begin
        w_grant   = '0;
        w_found   = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_idx  = '0;
        w_wr_data = '0;
        if (r_state_q == S_CLEAR) begin
            w_wr_en  = 1'b1;
            w_wr_idx = r_ptr_q;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!w_found && bus.i_we[p] && w_in_range[p]) begin
                    w_found      = 1'b1;
                    w_grant[p]   = 1'b1;
                    w_wr_en      = 1'b1;
                    w_wr_idx     = w_rd_idx[p];
                    w_wr_data    = bus.i_wdata[p];
                end
            end
        end
    end

    assign w_drop_d = bus.i_we & ~w_grant;

    // Read path; the bypass applies to every port including the writer.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_rdata_d[p] = '0;
            if (w_in_range[p]) begin
                if ((WRITE_FIRST != 0) && w_wr_en && (w_wr_idx == w_rd_idx[p])) begin
                    w_rdata_d[p] = w_wr_data;
                end else begin
                    w_rdata_d[p] = mem[w_rd_idx[p]];
                end
            end
        end
    end

    // Clear sequencer: i_clear is only looked at in IDLE.
    always_comb begin
        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        case (r_state_q)
            S_IDLE: begin
                if (i_clear) begin
                    w_state_d = S_CLEAR;
                    w_ptr_d   = '0;
                end
            end
            S_CLEAR: begin
                if (r_ptr_q == c_LAST_IDX) begin
                    w_state_d = S_IDLE;
                    w_ptr_d   = '0;
                end else begin
                    w_ptr_d   = r_ptr_q + IDX_W'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state_q <= S_IDLE;
            r_ptr_q   <= '0;
            r_busy_q  <= 1'b0;
            r_rdata_q <= '0;
            r_drop_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_ptr_q   <= w_ptr_d;
            r_busy_q  <= (w_state_d == S_CLEAR);
            r_rdata_q <= w_rdata_d;
            r_drop_q  <= w_drop_d;
        end
    end

    // Array storage is deliberately outside the reset domain.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            mem[w_wr_idx] <= w_wr_data;
        end
    end

    assign bus.o_rdata = r_rdata_q;
    assign bus.o_drop  = r_drop_q;
    assign o_busy      = r_busy_q;

`ifdef COUNTER_SRAM_STATS_EN
    logic [15:0] r_cnt_q, w_cnt_d;
    logic [16:0] w_cnt_sum;

    always_comb begin
        w_cnt_sum = {1'b0, r_cnt_q} + 17'($countones(w_drop_d));
        if ((r_state_q == S_IDLE) && i_clear) begin
            w_cnt_d = '0;
        end else if (w_cnt_sum[16]) begin
            w_cnt_d = 16'hFFFF;
        end else begin
            w_cnt_d = w_cnt_sum[15:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_drop_cnt = r_cnt_q;
`endif

endmodule
`default_nettype wire
